// File: rtl/dmem_stall_ctrl_if.sv
// rtl/dmem_stall_ctrl_if.sv - datapath <-> multi-cycle data memory handshake bundle
interface dmem_stall_ctrl_if #(
  parameter int n = 16
);
  logic         memread;
  logic         memwrite;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic [n-1:0] readdata;
  logic         pc_enable;
  logic         busy;
  logic         misalign;

  modport master (
    output memread, memwrite, addr, wdata,
    input  readdata, pc_enable, busy, misalign
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output readdata, pc_enable, busy, misalign
  );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - word-addressed RAM with fixed access latency that stalls the datapath PC
module dmem_stall_ctrl #(
  parameter int n       = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_stall_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic           op_wr_q, op_wr_d;
  logic [n-1:0]   readdata_q, readdata_d;
  logic           misalign_q, misalign_d;

  logic [n-1:0]   mem [DEPTH];
  logic           req;
  logic           pc_en;
  logic           busy;
  logic           mem_we;

  assign req = bus.memread | bus.memwrite;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    readdata_d = readdata_q;
    misalign_d = misalign_q;
    pc_en      = 1'b1;
    busy       = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Hold the PC in the same cycle the memory op is decoded.
        pc_en = ~req;
        if (req) begin
          idx_d   = bus.addr[AW:1];
          wdata_d = bus.wdata;
          op_wr_d = bus.memwrite;
          cnt_d   = '0;
          state_d = ACCESS;
          if (bus.addr[0]) misalign_d = 1'b1;
        end
      end
      ACCESS: begin
        pc_en = 1'b0;
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(LATENCY - 1)) begin
          state_d = DONE;
          mem_we  = op_wr_q;
          if (!op_wr_q) readdata_d = mem[idx_q];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      readdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      readdata_q <= readdata_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM is deliberately not reset; an aborted store must never land.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= wdata_q;
  end

  assign bus.pc_enable = reset | pc_en;
  assign bus.busy      = ~reset & busy;
  assign bus.readdata  = readdata_q;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb/tb_dmem_stall_ctrl.sv - directed table-driven bench for dmem_stall_ctrl
module tb_dmem_stall_ctrl;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_stall_ctrl_if #(.n(16)) bus ();

  dmem_stall_ctrl #(.n(16), .DEPTH(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd,
                       input logic exp_mis, input logic chg, input logic [15:0] chg_addr,
                       input string tag);
    @(negedge clk);
    bus.memread  = rd;
    bus.memwrite = wr;
    bus.addr     = addr;
    bus.wdata    = wdata;
    #1;
    check({tag, " req pc_enable"}, 16'(bus.pc_enable), 16'd0);
    check({tag, " req busy"}, 16'(bus.busy), 16'd0);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (chg && k == 0) begin
        bus.addr  = chg_addr;
        bus.wdata = 16'h9999;
      end
      #1;
      check($sformatf("%s access%0d pc_enable", tag, k), 16'(bus.pc_enable), 16'd0);
      check($sformatf("%s access%0d busy", tag, k), 16'(bus.busy), 16'd1);
    end
    @(negedge clk);
    #1;
    check({tag, " done pc_enable"}, 16'(bus.pc_enable), 16'd1);
    check({tag, " done busy"}, 16'(bus.busy), 16'd0);
    check({tag, " done readdata"}, bus.readdata, exp_rd);
    check({tag, " done misalign"}, 16'(bus.misalign), 16'(exp_mis));
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " idle pc_enable"}, 16'(bus.pc_enable), 16'd1);
    check({tag, " idle busy"}, 16'(bus.busy), 16'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'h1111, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0004, 16'h1234, 16'hBEEF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0030, 16'h0BAD, 16'h1234, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h0203, 16'hA5A5, 16'h1234, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'hA5A5, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0BAD, 1'b1};

    reset        = 1'b1;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset readdata", bus.readdata, 16'h0000);
    check("reset pc_enable", 16'(bus.pc_enable), 16'd1);
    check("reset busy", 16'(bus.busy), 16'd0);
    check("reset misalign", 16'(bus.misalign), 16'd0);
    bus.memread = 1'b1;
    #1;
    check("reset pc_enable with req", 16'(bus.pc_enable), 16'd1);
    bus.memread = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d pc_enable", c), 16'(bus.pc_enable), 16'd1);
      check($sformatf("idle%0d busy", c), 16'(bus.busy), 16'd0);
    end

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
            vecs[i].exp_mis, 1'b0, 16'h0000, $sformatf("vec%0d", i));

    do_op(1'b0, 1'b1, 16'h0010, 16'h5555, 16'h0BAD, 1'b1, 1'b1, 16'h0020, "chg_store");
    do_op(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0000, "chg_rd20");
    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b1, 1'b0, 16'h0000, "chg_rd10");

    // Abort a store in its second ACCESS cycle.
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.addr     = 16'h0030;
    bus.wdata    = 16'h7777;
    @(negedge clk);
    #1;
    check("abort access0 busy", 16'(bus.busy), 16'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort pc_enable", 16'(bus.pc_enable), 16'd1);
    check("abort busy", 16'(bus.busy), 16'd0);
    check("abort readdata", bus.readdata, 16'h0000);
    check("abort misalign", 16'(bus.misalign), 16'd0);
    bus.memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post-abort pc_enable", 16'(bus.pc_enable), 16'd1);
    check("post-abort busy", 16'(bus.busy), 16'd0);
    do_op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0BAD, 1'b0, 1'b0, 16'h0000, "abort_rd30");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
